// File: rtl/signal_field_parser_pkg.sv
// Shared definitions for the 802.11a/g SIGNAL field parser and its helpers.
package signal_field_parser_pkg;

  // Width of the SIGNAL field in bits
  localparam int SIG_W = 24;

  // Bit positions inside the SIGNAL field
  localparam int RATE_MSB   = 23;
  localparam int RATE_LSB   = 20;
  localparam int RSVD_POS   = 19;
  localparam int LEN_FIRST  = 18;  // LENGTH LSB, the first LENGTH bit on air
  localparam int LEN_W      = 12;
  localparam int PARITY_LSB = 6;   // parity covers RATE_MSB down to here
  localparam int TAIL_MSB   = 5;

  // Rate codes as they appear in SIGNAL[23:20]
  localparam logic [3:0] RATE_CODE_6  = 4'b1101;
  localparam logic [3:0] RATE_CODE_9  = 4'b1111;
  localparam logic [3:0] RATE_CODE_12 = 4'b0101;
  localparam logic [3:0] RATE_CODE_18 = 4'b0111;
  localparam logic [3:0] RATE_CODE_24 = 4'b1001;
  localparam logic [3:0] RATE_CODE_36 = 4'b1011;
  localparam logic [3:0] RATE_CODE_48 = 4'b0001;
  localparam logic [3:0] RATE_CODE_54 = 4'b0011;

  // Parser control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/signal_field_parser_rate_decode.sv
// Combinational SIGNAL rate-code lookup; shared with the transmit side.
module signal_rate_decode
  import signal_field_parser_pkg::*;
(
  input  logic [3:0] rate_bits,
  output logic [7:0] rate_mbps,
  output logic       rate_err
);

  // Map the 4-bit code to Mbps; unknown codes report 0 and flag an error
  always_comb begin
    rate_mbps = 8'd0;
    rate_err  = 1'b0;
    case (rate_bits)
      RATE_CODE_6:  rate_mbps = 8'd6;
      RATE_CODE_9:  rate_mbps = 8'd9;
      RATE_CODE_12: rate_mbps = 8'd12;
      RATE_CODE_18: rate_mbps = 8'd18;
      RATE_CODE_24: rate_mbps = 8'd24;
      RATE_CODE_36: rate_mbps = 8'd36;
      RATE_CODE_48: rate_mbps = 8'd48;
      RATE_CODE_54: rate_mbps = 8'd54;
      default:      rate_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/signal_field_parser.sv
// Serial SIGNAL field capture and decode: shifts in 24 bits MSB first,
// decodes rate/length, checks parity/reserved/tail/length, and holds the
// result until the consumer accepts it.
module signal_field_parser
  import signal_field_parser_pkg::*;
#(
  parameter bit TAIL_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [3:0]        rate_bits,
  output logic [7:0]        rate_mbps,
  output logic [LEN_W-1:0]  length,
  output logic              parity_err,
  output logic              rate_err,
  output logic              rsvd_err,
  output logic              tail_err,
  output logic              len_err,
  output logic              sig_ok
);

  localparam logic [4:0] LAST_BIT = 5'(SIG_W - 1);

  state_t             state, state_nxt;
  logic [4:0]         cnt_p0;
  logic [SIG_W-1:0]   sr_p0;
  logic               xfer, accept;
  logic [7:0]         dec_mbps;
  logic               dec_rate_err;

  // LENGTH is sent LSB first, so the field bits appear reversed
  function automatic logic [LEN_W-1:0] unpack_length(input logic [SIG_W-1:0] s);
    logic [LEN_W-1:0] l;
    for (int k = 0; k < LEN_W; k++) l[k] = s[LEN_FIRST - k];
    return l;
  endfunction

  // Even parity over rate, reserved and length: 1 means odd count
  function automatic logic parity_fail(input logic [SIG_W-1:0] s);
    return ^s[RATE_MSB:PARITY_LSB];
  endfunction

  // Tail bits must be zero when tail checking is enabled
  function automatic logic tail_fail(input logic [SIG_W-1:0] s);
    return TAIL_CHECK && (s[TAIL_MSB:0] != '0);
  endfunction

  assign bit_ready = (state == ST_SHIFT);
  assign sig_valid = (state == ST_HOLD);
  assign xfer      = bit_valid && bit_ready;
  assign accept    = sig_valid && sig_ready;
  assign sig_ok    = sig_valid && !(parity_err || rate_err || rsvd_err || tail_err || len_err);

  signal_rate_decode u_rate_decode (
    .rate_bits (sr_p0[RATE_MSB:RATE_LSB]),
    .rate_mbps (dec_mbps),
    .rate_err  (dec_rate_err)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start aborts anything in flight and rearms capture
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_SHIFT;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_SHIFT: if (xfer && (cnt_p0 == LAST_BIT)) state_nxt = ST_CHECK;
        ST_CHECK: state_nxt = ST_HOLD;
        ST_HOLD:  if (accept) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage 0: serial capture into the shift register with bit count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      sr_p0  <= '0;
    end else if (start) begin
      cnt_p0 <= '0;
    end else if (xfer) begin
      sr_p0  <= {sr_p0[SIG_W-2:0], bit_in};
      cnt_p0 <= cnt_p0 + 5'd1;
    end
  end

  // Stage 1: register decoded fields and error flags during CHECK
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_bits  <= '0;
      rate_mbps  <= '0;
      length     <= '0;
      parity_err <= 1'b0;
      rate_err   <= 1'b0;
      rsvd_err   <= 1'b0;
      tail_err   <= 1'b0;
      len_err    <= 1'b0;
    end else if ((state == ST_CHECK) && !start) begin
      rate_bits  <= sr_p0[RATE_MSB:RATE_LSB];
      rate_mbps  <= dec_mbps;
      length     <= unpack_length(sr_p0);
      parity_err <= parity_fail(sr_p0);
      rate_err   <= dec_rate_err;
      rsvd_err   <= sr_p0[RSVD_POS];
      tail_err   <= tail_fail(sr_p0);
      len_err    <= (unpack_length(sr_p0) == '0);
    end
  end

endmodule

// File: tb/tb_signal_field_parser.sv
// Testbench for signal_field_parser: directed and random SIGNAL fields
// against a behavioural model, with TAIL_CHECK=1 and TAIL_CHECK=0 instances.
module tb_signal_field_parser;

  logic clk = 1'b0;
  logic rst, start, bit_in, bit_valid, sig_ready;

  logic bit_ready, sig_valid, parity_err, rate_err, rsvd_err, tail_err, len_err, sig_ok;
  logic [3:0] rate_bits;
  logic [7:0] rate_mbps;
  logic [11:0] length;

  logic bit_ready_t0, sig_valid_t0, parity_err_t0, rate_err_t0, rsvd_err_t0, tail_err_t0, len_err_t0, sig_ok_t0;
  logic [3:0] rate_bits_t0;
  logic [7:0] rate_mbps_t0;
  logic [11:0] length_t0;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0]  rb;
    logic [7:0]  mbps;
    logic [11:0] len;
    logic        par, rate, rsvd, tail, lenerr, ok;
  } exp_t;

  signal_field_parser dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .sig_valid(sig_valid), .sig_ready(sig_ready),
    .rate_bits(rate_bits), .rate_mbps(rate_mbps), .length(length),
    .parity_err(parity_err), .rate_err(rate_err), .rsvd_err(rsvd_err),
    .tail_err(tail_err), .len_err(len_err), .sig_ok(sig_ok)
  );

  signal_field_parser #(.TAIL_CHECK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_t0), .sig_valid(sig_valid_t0), .sig_ready(sig_ready),
    .rate_bits(rate_bits_t0), .rate_mbps(rate_mbps_t0), .length(length_t0),
    .parity_err(parity_err_t0), .rate_err(rate_err_t0), .rsvd_err(rsvd_err_t0),
    .tail_err(tail_err_t0), .len_err(len_err_t0), .sig_ok(sig_ok_t0)
  );

  always #5 clk = ~clk;

  // Reference model: table lookup for rate, bit reversal for length
  function automatic exp_t model(input logic [23:0] w, input bit tc);
    exp_t e;
    logic [3:0] codes [8];
    int mb [8];
    codes = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0001, 4'b0011};
    mb    = '{6, 9, 12, 18, 24, 36, 48, 54};
    e.rb = w[23:20];
    e.mbps = 8'd0;
    e.rate = 1'b1;
    for (int i = 0; i < 8; i++)
      if (codes[i] == e.rb) begin e.mbps = 8'(mb[i]); e.rate = 1'b0; end
    e.rsvd = w[19];
    for (int k = 0; k < 12; k++) e.len[k] = w[18-k];
    e.par = ($countones(w[23:6]) % 2) == 1;
    e.tail = tc && (w[5:0] != 6'd0);
    e.lenerr = (e.len == 12'd0);
    e.ok = !(e.par || e.rate || e.rsvd || e.tail || e.lenerr);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input logic [23:0] w, input string tag);
    exp_t a, b;
    a = model(w, 1'b1);
    b = model(w, 1'b0);
    chk({tag, ".sig_valid"}, sig_valid, 1);
    chk({tag, ".bit_ready"}, bit_ready, 0);
    chk({tag, ".rate_bits"}, rate_bits, a.rb);
    chk({tag, ".rate_mbps"}, rate_mbps, a.mbps);
    chk({tag, ".length"}, length, a.len);
    chk({tag, ".parity_err"}, parity_err, a.par);
    chk({tag, ".rate_err"}, rate_err, a.rate);
    chk({tag, ".rsvd_err"}, rsvd_err, a.rsvd);
    chk({tag, ".tail_err"}, tail_err, a.tail);
    chk({tag, ".len_err"}, len_err, a.lenerr);
    chk({tag, ".sig_ok"}, sig_ok, a.ok);
    chk({tag, ".t0.sig_valid"}, sig_valid_t0, 1);
    chk({tag, ".t0.length"}, length_t0, b.len);
    chk({tag, ".t0.rate_mbps"}, rate_mbps_t0, b.mbps);
    chk({tag, ".t0.tail_err"}, tail_err_t0, b.tail);
    chk({tag, ".t0.sig_ok"}, sig_ok_t0, b.ok);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".sig_valid"}, sig_valid, 0);
    chk({tag, ".bit_ready"}, bit_ready, 0);
    chk({tag, ".sig_ok"}, sig_ok, 0);
    chk({tag, ".rate_bits"}, rate_bits, 0);
    chk({tag, ".rate_mbps"}, rate_mbps, 0);
    chk({tag, ".length"}, length, 0);
    chk({tag, ".errs"}, {parity_err, rate_err, rsvd_err, tail_err, len_err}, 0);
    chk({tag, ".t0.sig_valid"}, sig_valid_t0, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap_mode 0: continuous, 1: 3-cycle gaps at two points, 2: random gaps
  task automatic send_bits(input logic [23:0] w, input int first, input int last, input int gap_mode);
    for (int i = first; i >= last; i--) begin
      if ((gap_mode == 1 && (i == 15 || i == 8)) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        repeat (gap_mode == 1 ? 3 : $urandom_range(1, 3)) begin
          bit_valid = 1'b0;
          bit_in = 1'($urandom);
          @(negedge clk);
        end
      end
      chk("shift.bit_ready", bit_ready, 1);
      bit_valid = 1'b1;
      bit_in = w[i];
      @(negedge clk);
    end
    bit_valid = 1'b0;
  endtask

  // Capture a full field and check the 2-cycle latency and the result
  task automatic run_field(input logic [23:0] w, input string tag, input int gap_mode);
    pulse_start();
    send_bits(w, 23, 0, gap_mode);
    chk({tag, ".lat1_valid"}, sig_valid, 0);
    chk({tag, ".lat1_ready"}, bit_ready, 0);
    @(negedge clk);
    chk_fields(w, tag);
  endtask

  task automatic accept(input string tag);
    sig_ready = 1'b1;
    @(negedge clk);
    sig_ready = 1'b0;
    chk({tag, ".acc_valid"}, sig_valid, 0);
    chk({tag, ".acc_ready"}, bit_ready, 0);
    chk({tag, ".t0.acc_valid"}, sig_valid_t0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    int hold;
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sig_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // bit_valid in IDLE is ignored
    repeat (4) begin
      bit_valid = 1'b1;
      bit_in = 1'($urandom);
      @(negedge clk);
      chk("idle.bit_ready", bit_ready, 0);
      chk("idle.sig_valid", sig_valid, 0);
    end
    bit_valid = 1'b0;

    // Basic field with sig_ready held high throughout
    sig_ready = 1'b1;
    run_field(24'hB13000, "b13000", 0);
    chk("b13000.mbps36", rate_mbps, 36);
    chk("b13000.len100", length, 100);
    chk("b13000.ok", sig_ok, 1);
    accept("b13000");

    run_field(24'hD7FFC0, "d7ffc0", 0);
    chk("d7ffc0.mbps6", rate_mbps, 6);
    chk("d7ffc0.len4095", length, 4095);
    chk("d7ffc0.par0", parity_err, 0);
    accept("d7ffc0");

    run_field(24'hD7FF80, "d7ff80", 0);
    chk("d7ff80.par1", parity_err, 1);
    chk("d7ff80.ok0", sig_ok, 0);
    accept("d7ff80");

    run_field(24'h813000, "813000", 0);
    chk("813000.rate_err", rate_err, 1);
    chk("813000.mbps0", rate_mbps, 0);
    chk("813000.len100", length, 100);
    chk("813000.par0", parity_err, 0);
    accept("813000");

    // Backpressure: result stays stable in HOLD
    run_field(24'hB13000, "hold", 0);
    repeat (5) begin
      @(negedge clk);
      chk_fields(24'hB13000, "hold.stable");
    end
    accept("hold");

    // Abort after 10 bits, then a full field gives a single result
    pulse_start();
    send_bits(24'h5A5A5A, 23, 14, 0);
    run_field(24'hB13000, "abort_shift", 0);
    chk("abort_shift.len100", length, 100);
    accept("abort_shift");

    // Abort while a result is pending
    run_field(24'hD7FFC0, "pend", 0);
    pulse_start();
    chk("abort_hold.sig_valid", sig_valid, 0);
    chk("abort_hold.bit_ready", bit_ready, 1);
    send_bits(24'hB13000, 23, 0, 0);
    @(negedge clk);
    chk_fields(24'hB13000, "abort_hold");
    accept("abort_hold");

    // Gaps of 3 cycles mid-field
    run_field(24'hB13000, "gaps", 1);
    chk("gaps.len100", length, 100);
    accept("gaps");

    // Nonzero tail: flagged only when tail checking is on
    run_field(24'hB1303F, "tail", 0);
    chk("tail.err1", tail_err, 1);
    chk("tail.t0.err0", tail_err_t0, 0);
    chk("tail.t0.ok", sig_ok_t0, 1);
    accept("tail");

    // Random fields, random gaps and backpressure
    for (int n = 0; n < 16; n++) begin
      w = 24'($urandom);
      if (n % 4 == 0) w[23:20] = 4'b1011;
      run_field(w, "rand", 2);
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(negedge clk);
        chk_fields(w, "rand.hold");
      end
      accept("rand");
    end

    // Reset in HOLD clears everything
    run_field(24'hB13000, "rst_hold", 0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b0;

    // Reset mid-SHIFT, and reset beats start
    pulse_start();
    send_bits(24'hD7FFC0, 23, 12, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_shift");
    start = 1'b1;
    @(negedge clk);
    chk("rst_over_start.bit_ready", bit_ready, 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst.bit_ready", bit_ready, 0);
    run_field(24'hD7FFC0, "after_rst", 0);
    accept("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/signal_field_parser.md
SIGNAL_FIELD_PARSER -- requirements
Module: signal_field_parser

Interface
REQ-001 Parameter TAIL_CHECK, default 1; when 1, nonzero tail bits raise tail_err, and when 0, tail bits are ignored.
REQ-002 clk  in  1  sole clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high (fixed decision).
REQ-004 start  in  1  one-cycle pulse that arms the capture of a new 24-bit SIGNAL field.
REQ-005 bit_in  in  1  serial SIGNAL bit from the Viterbi decoder; SIGNAL[23] first, SIGNAL[0] last.
REQ-006 bit_valid  in  1  bit_in is meaningful this cycle.
REQ-007 bit_ready  out  1  parser accepts a bit this cycle; a bit transfers only when bit_valid and bit_ready are both high.
REQ-008 sig_valid  out  1  decoded fields and error flags are valid; held until accepted.
REQ-009 sig_ready  in  1  downstream accepts the result; transfer occurs when sig_valid and sig_ready are both high.
REQ-010 rate_bits  out  4  raw SIGNAL[23:20].
REQ-011 rate_mbps  out  8  decoded rate: 6/9/12/18/24/36/48/54, or 0 if invalid.
REQ-012 length  out  12  decoded LENGTH in octets.
REQ-013 parity_err, rate_err, rsvd_err, tail_err, len_err  out  1 each  per-field error flags.
REQ-014 sig_ok  out  1  set when sig_valid is high and all error flags are low.

Function
REQ-015 States: IDLE, SHIFT, CHECK, HOLD; the state register is encoded and resets to IDLE.
REQ-016 IDLE: bit_ready=0; start moves the FSM to SHIFT and clears the 5-bit bit counter.
REQ-017 SHIFT: bit_ready=1; each transfer shifts bit_in into the LSB of a 24-bit register and increments the counter; on the 24th transfer the FSM moves to CHECK.
REQ-018 A start pulse during SHIFT, CHECK or HOLD aborts the current field: counter=0, sig_valid drops, FSM goes to SHIFT on the next cycle, and any pending result is discarded.
REQ-019 CHECK lasts one cycle with bit_ready=0; it registers all outputs, then the FSM goes to HOLD.
REQ-020 Latency: sig_valid rises exactly 2 cycles after the clock edge that transfers the 24th bit.
REQ-021 HOLD: sig_valid=1 and all outputs stay stable until sig_valid && sig_ready, after which the FSM returns to IDLE the next cycle.
REQ-022 Rate map (rate_bits to Mbps): 1101→6, 1111→9, 0101→12, 0111→18, 1001→24, 1011→36, 0001→48, 0011→54; any other code gives rate_mbps=0 and rate_err=1.
REQ-023 rsvd_err = SIGNAL[19].
REQ-024 length[k] = SIGNAL[18-k] for k = 0..11, i.e. LENGTH is transmitted LSB first.
REQ-025 parity_err = XOR of SIGNAL[23:6], which is 1 when parity is odd; the parity check is even parity.
REQ-026 tail_err = TAIL_CHECK && (SIGNAL[5:0] != 0).
REQ-027 len_err = (length == 0).
REQ-028 Decoded fields are still reported when error flags are set; no field is masked except rate_mbps, which is forced to 0 on rate_err.
REQ-029 bit_valid while bit_ready=0 is ignored, with no shift and no count.
REQ-030 sig_ready while sig_valid=0 is ignored.

Reset
REQ-031 On rst, synchronously: state=IDLE, counter=0, shift register=0, and all outputs 0 (bit_ready, sig_valid, sig_ok, rate_bits, rate_mbps, length, and every error flag).
REQ-032 rst mid-SHIFT or mid-HOLD discards the partial or pending field; rst has priority over start.

Structure
REQ-033 A shared package holds the state enum, the eight 4-bit rate-code constants, the SIGNAL field bit-position constants, and the 24-bit field width.
REQ-034 Sub-module signal_rate_decode holds the combinational rate_bits→{rate_mbps, rate_err} lookup and is reused by the transmit side for consistency checks.

Verification
REQ-035 start, then serial 0xB13000 with bit_valid continuous, sig_ready=1 → rate_mbps=36, length=100, sig_ok=1, sig_valid 2 cycles after the last bit.
REQ-036 Serial 0xD7FFC0 → rate_mbps=6, length=4095, parity_err=0; flipping bit 6 (0xD7FF80) → parity_err=1, sig_ok=0.
REQ-037 Serial 0x813000 (rate code 1000) → rate_err=1, rate_mbps=0, length=100; the parity result is also checked.
REQ-038 sig_ready held at 0 for 5 cycles in HOLD → sig_valid stays 1 with stable outputs and bit_ready=0; sig_ready=1 → IDLE the next cycle.
REQ-039 start asserted after 10 bits, then a full 0xB13000 → a single result with length=100; bit_valid gaps of 3 cycles mid-field leave the result unchanged.
REQ-040 rst asserted in HOLD → the next cycle shows sig_valid=0 and all outputs 0; with TAIL_CHECK=0, 0xB1303F is accepted with tail_err=0.
